// File: rtl/cpu_step_gen_if.sv
// Board-side signal bundle for cpu_step_gen: mode switches and step key in,
// CPU clock-enable, step count and run indicator out.
interface cpu_step_gen_if;
    logic [1:0] mode;
    logic       step_key;
    logic       cpu_en;
    logic [7:0] step_cnt;
    logic       run_led;

    modport master (output mode, output step_key,
                    input  cpu_en, input step_cnt, input run_led);
    modport slave  (input  mode, input step_key,
                    output cpu_en, output step_cnt, output run_led);
endinterface

// File: rtl/cpu_step_gen.sv
// CPU single-step / slow-clock enable generator: HALT, 1 Hz, 10 Hz or
// debounced manual key stepping, producing one-cycle CPU clock enables.
module cpu_step_gen #(
    parameter int unsigned CLK_HZ          = 100_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic          clk,
    input  logic          rst_n,
    cpu_step_gen_if.slave bus
);
    localparam int unsigned DIV_SLOW = CLK_HZ;
    localparam int unsigned DIV_FAST = CLK_HZ / 10;
    localparam int unsigned PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {
        HALT   = 2'b00,
        SLOW   = 2'b01,
        FAST   = 2'b10,
        MANUAL = 2'b11
    } mode_t;

    logic [1:0]    mode_s1, mode_s2;
    mode_t         mode_q, mode_prev, mode_d;
    logic          key_s1, key_s2, key_db, key_db_prev;
    logic [DW-1:0] db_cnt;
    logic [PW-1:0] presc, presc_eff, presc_nx, div_last;
    logic          changed, running, tick, press, en_nx;
    logic          cpu_en_q;
    logic [7:0]    step_cnt_q;

    // Synchronisers plus the mode register and its one-cycle history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_s1   <= '0;
            mode_s2   <= '0;
            key_s1    <= 1'b1;
            key_s2    <= 1'b1;
            mode_q    <= HALT;
            mode_prev <= HALT;
        end else begin
            mode_s1   <= bus.mode;
            mode_s2   <= mode_s1;
            key_s1    <= bus.step_key;
            key_s2    <= key_s1;
            mode_q    <= mode_d;
            mode_prev <= mode_q;
        end
    end

    // A mode change forces the prescaler to read as 0 in the change cycle
    // itself, so the first tick lands exactly DIV cycles after the change
    // and any tick pending in the old mode is dropped.
    always_comb begin
        mode_d    = mode_t'(mode_s2);
        changed   = (mode_q != mode_prev);
        running   = (mode_q == SLOW) || (mode_q == FAST);
        div_last  = (mode_q == FAST) ? PW'(DIV_FAST - 1) : PW'(DIV_SLOW - 1);
        presc_eff = changed ? '0 : presc;
        tick      = running && !changed && (presc_eff == div_last);
        presc_nx  = '0;
        if (running && (presc_eff != div_last))
            presc_nx = presc_eff + 1'b1;
        press     = key_db_prev && !key_db;
        en_nx     = tick || (press && (mode_q == MANUAL));
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            presc <= '0;
        else
            presc <= presc_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_cnt      <= '0;
            key_db      <= 1'b1;
            key_db_prev <= 1'b1;
        end else begin
            key_db_prev <= key_db;
            if (key_s2 == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                key_db <= key_s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_en_q   <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            cpu_en_q   <= en_nx;
            step_cnt_q <= step_cnt_q + 8'(cpu_en_q);
        end
    end

    assign bus.cpu_en   = cpu_en_q;
    assign bus.step_cnt = step_cnt_q;
    assign bus.run_led  = running;
endmodule

// File: tb/tb_cpu_step_gen.sv
// Randomised and directed bench for cpu_step_gen against a history-based
// reference model (CLK_HZ=100, DEBOUNCE_CYCLES=4).
module tb_cpu_step_gen;
    localparam int unsigned CLK_HZ = 100;
    localparam int unsigned DB     = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cpu_step_gen_if bus();

    cpu_step_gen #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: values after edge n since the last reset edge (n=0),
    // derived from the input history in a ring buffer.
    int          n = 0;
    int          lastchg = 0;
    bit [1:0]    m_mode_in[1024];
    bit          m_key_in[1024];
    bit [1:0]    m_mreg[1024];
    bit          m_ks[1024];
    bit          m_kdb[1024];
    bit          m_press[1024];
    bit          m_tick[1024];
    bit          m_en[1024];
    int unsigned m_cnt = 0;

    function automatic int h(input int i);
        return i & 1023;
    endfunction

    function automatic int div_of(input bit [1:0] m);
        return (m == 2'b10) ? 10 : 100;
    endfunction

    task automatic model_edge(input bit rst, input logic [1:0] mi, input logic ki);
        bit flip;
        bit run;
        if (rst) begin
            n = 0; lastchg = 0; m_cnt = 0;
            m_mreg[0] = 2'b00; m_ks[0] = 1'b1; m_kdb[0] = 1'b1;
            m_press[0] = 1'b0; m_tick[0] = 1'b0; m_en[0] = 1'b0;
            return;
        end
        n++;
        m_mode_in[h(n)] = mi;
        m_key_in[h(n)]  = ki;
        m_mreg[h(n)] = (n >= 3) ? m_mode_in[h(n-2)] : 2'b00;
        m_ks[h(n)]   = (n >= 2) ? m_key_in[h(n-1)] : 1'b1;
        // key_db flips once the last DB synchronised samples all disagree with it
        flip = (n >= int'(DB));
        for (int i = 1; i <= int'(DB); i++)
            if (flip && m_ks[h(n-i)] == m_kdb[h(n-1)]) flip = 1'b0;
        m_kdb[h(n)]   = flip ? !m_kdb[h(n-1)] : m_kdb[h(n-1)];
        m_press[h(n)] = m_kdb[h(n-1)] && !m_kdb[h(n)];
        if (m_mreg[h(n)] != m_mreg[h(n-1)]) lastchg = n;
        run = (m_mreg[h(n)] == 2'b01) || (m_mreg[h(n)] == 2'b10);
        m_tick[h(n)] = run && (((n - lastchg) % div_of(m_mreg[h(n)])) == div_of(m_mreg[h(n)]) - 1);
        m_cnt = (m_cnt + 32'(m_en[h(n-1)])) % 256;
        m_en[h(n)] = m_tick[h(n-1)] || (m_press[h(n-1)] && m_mreg[h(n-1)] == 2'b11);
    endtask

    int cyc = 0;
    int last_pulse = -1;
    int last_gap = 0;
    int npulse = 0;

    task automatic cycle();
        bit exp_run;
        @(posedge clk);
        model_edge(!rst_n, bus.mode, bus.step_key);
        cyc++;
        @(negedge clk);
        exp_run = (m_mreg[h(n)] == 2'b01) || (m_mreg[h(n)] == 2'b10);
        check("cpu_en",   32'(bus.cpu_en),   32'(m_en[h(n)]));
        check("step_cnt", 32'(bus.step_cnt), m_cnt);
        check("run_led",  32'(bus.run_led),  32'(exp_run));
        check("key_db",   32'(dut.key_db),   32'(m_kdb[h(n)]));
        if (bus.cpu_en) begin
            if (last_pulse >= 0) last_gap = cyc - last_pulse;
            last_pulse = cyc;
            npulse++;
        end
    endtask

    initial begin
        int c0;
        int p0;
        bit found;
        rst_n = 1'b0;
        bus.mode = 2'b00;
        bus.step_key = 1'b1;
        repeat (3) cycle();
        check("rst_cpu_en",   32'(bus.cpu_en),   0);
        check("rst_step_cnt", 32'(bus.step_cnt), 0);
        check("rst_run_led",  32'(bus.run_led),  0);

        // SLOW from reset: three pulses, 100 cycles apart
        rst_n = 1'b1;
        bus.mode = 2'b01;
        repeat (310) cycle();
        check("slow_steps", 32'(bus.step_cnt), 3);
        check("slow_gap", 32'(last_gap), 100);
        check("slow_led", 32'(bus.run_led), 1);

        // FAST, then back to SLOW mid-count
        bus.mode = 2'b10;
        repeat (45) cycle();
        check("fast_gap", 32'(last_gap), 10);
        bus.mode = 2'b01;
        c0 = cyc;
        repeat (110) cycle();
        check("fast2slow_delay", 32'(last_pulse - c0), 103);

        // MANUAL: one long press, one pulse 7 edges after the key edge is sampled
        bus.mode = 2'b11;
        repeat (10) cycle();
        p0 = npulse;
        bus.step_key = 1'b0;
        c0 = cyc;
        repeat (20) cycle();
        bus.step_key = 1'b1;
        repeat (20) cycle();
        check("manual_pulses", 32'(npulse - p0), 1);
        check("manual_latency", 32'(last_pulse - c0), 7);

        // Short glitches never pass the debouncer
        p0 = npulse;
        for (int g = 0; g < 5; g++) begin
            bus.step_key = 1'b0;
            repeat (3) cycle();
            bus.step_key = 1'b1;
            repeat (3) cycle();
        end
        repeat (10) cycle();
        check("glitch_pulses", 32'(npulse - p0), 0);
        check("glitch_key_db", 32'(dut.key_db), 1);

        // HALT with key activity
        bus.mode = 2'b00;
        p0 = npulse;
        for (int t = 0; t < 1000; ) begin
            int len;
            len = $urandom_range(5, 30);
            bus.step_key = ~bus.step_key;
            repeat (len) cycle();
            t += len;
        end
        bus.step_key = 1'b1;
        repeat (10) cycle();
        check("halt_pulses", 32'(npulse - p0), 0);

        // 256 FAST steps wrap the counter back to its start value
        bus.mode = 2'b10;
        p0 = npulse;
        repeat (2565) cycle();
        check("wrap_pulses", 32'(npulse - p0), 256);

        // Reset while the SLOW prescaler is at 95
        bus.mode = 2'b01;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            cycle();
            found = (n >= 3) && (m_mreg[h(n)] == 2'b01) && (m_mreg[h(n-1)] == 2'b01)
                    && (((n - lastchg) % 100) == 95);
        end
        check("presc95_reached", 32'(found), 1);
        rst_n = 1'b0;
        cycle();
        check("mid_rst_cpu_en",   32'(bus.cpu_en),   0);
        check("mid_rst_step_cnt", 32'(bus.step_cnt), 0);
        check("mid_rst_run_led",  32'(bus.run_led),  0);
        rst_n = 1'b1;
        c0 = cyc;
        p0 = npulse;
        repeat (200) cycle();
        check("post_rst_pulses", 32'(npulse - p0), 1);
        check("post_rst_delay_ok", 32'((last_pulse - c0) >= 100), 1);

        // Random mix of modes, key activity and occasional resets
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 199) == 0) bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) bus.step_key = ~bus.step_key;
            rst_n = ($urandom_range(0, 599) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu_step_gen.md
CPU_STEP_GEN -- requirements
Module: cpu_step_gen

Parameters
REQ-001 CLK_HZ, default 100_000_000: input clock frequency; sets the SLOW divisor to CLK_HZ and the FAST divisor to CLK_HZ/10.
REQ-002 DEBOUNCE_CYCLES, default 1_000_000: number of consecutive stable synchronised samples needed to accept a new key level (10 ms at 100 MHz).

Interface
REQ-003 CLK  input  1  single system clock; all state updates on the rising edge.
REQ-004 RST_N  input  1  synchronous, active-low reset.
REQ-005 MODE  input  2  00 HALT, 01 SLOW (1 Hz), 10 FAST (10 Hz), 11 MANUAL; asynchronous board switches.
REQ-006 STEP_KEY  input  1  raw pushbutton, active-low, asynchronous, bouncy.
REQ-007 CPU_EN  output  1  single-cycle clock-enable pulse consumed by the CPU core.
REQ-008 STEP_CNT  output  8  count of CPU_EN pulses issued since reset.
REQ-009 RUN_LED  output  1  high when the mode register holds SLOW or FAST.

Function
REQ-010 MODE SHALL pass through a 2-FF synchroniser into a mode register; the states are HALT, SLOW, FAST and MANUAL.
REQ-011 The block SHALL latch the mode register's previous value each cycle; when the current value differs from the previous value, the prescaler SHALL clear to 0 in that cycle.
REQ-012 STEP_KEY SHALL pass through a 2-FF synchroniser whose stages reset to 1.
REQ-013 Debounce:
- key_db (reset 1) SHALL take the synchronised level after that level has differed from key_db for DEBOUNCE_CYCLES consecutive cycles.
- The debounce counter SHALL clear in any cycle where the synchronised level equals key_db.
REQ-014 A press event SHALL be a 1->0 transition of key_db; a 0->1 transition (release) SHALL generate no event.
REQ-015 Prescaler:
- In SLOW and FAST, the prescaler SHALL count 0..DIV-1 (DIV = CLK_HZ in SLOW, CLK_HZ/10 in FAST).
- At DIV-1 it SHALL wrap to 0 and raise an internal tick.
- In HALT and MANUAL, the prescaler SHALL be held at 0.
REQ-016 CPU_EN SHALL be registered, SHALL be high for exactly one cycle, and SHALL be asserted in the cycle after either:
- a tick in SLOW or FAST; or
- a press event in MANUAL.
REQ-017 Press events outside MANUAL SHALL be discarded, not queued.
REQ-018 A tick and a press event can never be accepted in the same mode; if a mode change coincides with a pending tick, the tick SHALL be dropped.
REQ-019 In HALT, CPU_EN SHALL stay 0 indefinitely.
REQ-020 STEP_CNT SHALL increment by 1 in the cycle after each CPU_EN pulse and SHALL wrap from 255 to 0.
REQ-021 Holding STEP_KEY low for any duration SHALL produce exactly one CPU_EN pulse per press.

Reset
REQ-022 While RST_N=0 at a clock edge, the following SHALL load the values shown:
- CPU_EN=0, STEP_CNT=0, RUN_LED=0;
- mode register = HALT;
- prescaler = 0, debounce counter = 0;
- key_db = 1, synchroniser stages = 1.
REQ-023 Reset asserted mid-count or during a debounce window SHALL abandon the count or window; no CPU_EN SHALL be issued for it after reset is released.
REQ-024 After reset is released, the first tick SHALL occur a full DIV cycles after the mode register reaches SLOW or FAST.

Verification (CLK_HZ=100, DEBOUNCE_CYCLES=4)
REQ-025 MODE=01 from reset -> CPU_EN pulses exactly every 100 cycles, each 1 cycle wide, and RUN_LED=1; after 3 pulses STEP_CNT=3.
REQ-026 MODE=10 -> pulse spacing 10 cycles; switching to 01 mid-count clears the prescaler, and the next pulse comes 100 cycles after the mode register changes.
REQ-027 MODE=11, STEP_KEY low for 20 cycles then high -> exactly one CPU_EN, asserted 2+4+1 cycles after the falling edge reaches the synchroniser input; STEP_CNT=1.
REQ-028 MODE=11, STEP_KEY glitches low for 3 cycles, 5 times -> no CPU_EN, and key_db stays 1.
REQ-029 MODE=00 for 1000 cycles with key presses -> CPU_EN stays 0 and STEP_CNT stays 0; 256 steps in FAST -> STEP_CNT wraps to 0.
REQ-030 RST_N pulled low for 1 cycle at prescaler value 95 in SLOW -> all outputs return to their reset values, and the next CPU_EN occurs no earlier than 100 cycles after release.
